// File: rtl/pipereg_if_id_skid.sv
// IF/ID pipeline register as a 2-entry elastic stage (main + skid) with valid/ready handshake,
// flush and NOP bubble insertion on the outputs when no instruction is held.
module pipereg_if_id_skid #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             PC_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]   NOP_INS    = DATA_WIDTH'(32'h00000013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ins_in,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [PC_WIDTH-1:0]   pc_plus4_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ins_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] main_ins, skid_ins;
  logic [PC_WIDTH-1:0]   main_pc, skid_pc;
  logic [PC_WIDTH-1:0]   main_pc4, skid_pc4;
  logic                  main_valid;
  logic                  accept;
  logic                  pop;

  assign main_valid = (state != EMPTY);
  assign in_ready   = (state != FULL) & ~rst;
  assign accept     = in_valid & in_ready;
  assign pop        = main_valid & out_ready;

  // Bubbles are produced by masking on main_valid; the main register keeps its stale payload.
  always_comb begin
    out_valid    = main_valid;
    ins_out      = main_valid ? main_ins : NOP_INS;
    pc_out       = main_valid ? main_pc  : '0;
    pc_plus4_out = main_valid ? main_pc4 : '0;
    occupancy    = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      main_ins <= '0;
      main_pc  <= '0;
      main_pc4 <= '0;
      skid_ins <= '0;
      skid_pc  <= '0;
      skid_pc4 <= '0;
    end else if (clr) begin
      // Flush wins over any accept; a concurrent pop has already been seen by decode.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_ins <= ins_in;
            main_pc  <= pc_in;
            main_pc4 <= pc_plus4_in;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ins <= ins_in;
            main_pc  <= pc_in;
            main_pc4 <= pc_plus4_in;
          end else if (accept) begin
            skid_ins <= ins_in;
            skid_pc  <= pc_in;
            skid_pc4 <= pc_plus4_in;
            state    <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_ins <= skid_ins;
            main_pc  <= skid_pc;
            main_pc4 <= skid_pc4;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipereg_if_id_skid.sv
// Self-checking bench for pipereg_if_id_skid: directed scenarios then random traffic,
// all compared against a FIFO-queue reference model of the stage.
module tb_pipereg_if_id_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] ins_in, pc_in, pc_plus4_in;
  logic [31:0] ins_out, pc_out, pc_plus4_out;
  logic [1:0]  occupancy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference: the stage is a 2-deep FIFO of {ins, pc, pc4}.
  logic [95:0] model_q[$];

  pipereg_if_id_skid #(
    .DATA_WIDTH (32),
    .PC_WIDTH   (32),
    .NOP_INS    (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ins_in       (ins_in),
    .pc_in        (pc_in),
    .pc_plus4_in  (pc_plus4_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ins_out      (ins_out),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle at the negedge, check outputs against the model, advance the model at posedge.
  task automatic step(input logic r, input logic c, input logic iv, input logic ordy,
                      input logic [31:0] ins, input logic [31:0] pc);
    logic [95:0] head;
    logic        acc, pp;
    rst = r; clr = c; in_valid = iv; out_ready = ordy;
    ins_in = ins; pc_in = pc; pc_plus4_in = pc + 32'd4;
    #1;
    head = (model_q.size() > 0) ? model_q[0] : {NOP, 32'd0, 32'd0};
    check("in_ready",  {31'd0, in_ready},  {31'd0, ~r && model_q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    check("ins_out",   ins_out,      head[95:64]);
    check("pc_out",    pc_out,       head[63:32]);
    check("pc4_out",   pc_plus4_out, head[31:0]);
    check("occupancy", {30'd0, occupancy}, model_q.size());
    @(posedge clk);
    acc = iv && !r && model_q.size() < 2;
    pp  = ordy && model_q.size() > 0;
    if (r || c) begin
      model_q.delete();
    end else begin
      if (pp)  void'(model_q.pop_front());
      if (acc) model_q.push_back({ins, pc, pc + 32'd4});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ins_in = '0; pc_in = '0; pc_plus4_in = '0;
    @(negedge clk);

    // Reset held two cycles, then idle
    step(1, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 1, 0, 32'hdead_beef, 32'h0);
    check("rst_nop", ins_out, NOP);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // Streaming with out_ready=1
    for (int unsigned i = 0; i < 3; i++)
      step(0, 0, 1, 1, 32'h00500093 + (i << 20), i * 4);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // Backpressure: A, B fill the stage, C refused, then drain
    step(0, 0, 1, 0, 32'h0000_00a1, 32'h100);
    step(0, 0, 1, 0, 32'h0000_00b2, 32'h104);
    step(0, 0, 1, 0, 32'h0000_00c3, 32'h108);
    check("full_occ", {30'd0, occupancy}, 32'd2);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // Flush while FULL with an incoming instruction
    step(0, 0, 1, 0, 32'h0000_0111, 32'h200);
    step(0, 0, 1, 0, 32'h0000_0222, 32'h204);
    step(0, 1, 1, 0, 32'h0000_0333, 32'h208);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // ONE with simultaneous accept and pop
    step(0, 0, 1, 0, 32'h0000_0444, 32'h300);
    step(0, 0, 1, 1, 32'h0000_0555, 32'h304);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // Reset while FULL under backpressure
    step(0, 0, 1, 0, 32'h0000_0666, 32'h400);
    step(0, 0, 1, 0, 32'h0000_0777, 32'h404);
    step(1, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // Random traffic
    for (int unsigned i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 1) == 1,
           (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom, $urandom & 32'hffff_fffc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
